// File: rtl/tpi_bus_arbiter_pkg.sv
// Shared definitions for the two-requester TPI bus arbiter: FSM encoding,
// default strobe timing and the requester count.
package tpi_bus_arbiter_pkg;

   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 4;

   localparam int DEF_SETUP_CYCLES  = 1;
   localparam int DEF_STROBE_CYCLES = 2;
   localparam int DEF_HOLD_CYCLES   = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Counters run N-1 .. 0, so a phase of N cycles loads N-1 on entry.
   function automatic logic [CNT_W-1:0] load_count(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/tpi_bus_arbiter_rr.sv
// Two-way round-robin picker: with both requests high, the requester that
// was not granted last wins; a single request is granted directly.
module rr_arbiter2
   import tpi_bus_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_grant,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      // NOTE: assign a default first so no path leaves grant unassigned (no latch).
      grant = '0;
      if (req[0] && req[1]) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/tpi_bus_arbiter.sv
// Arbitrates two requesters onto one TPI register port and sequences each
// access through SETUP, STROBE and HOLD phases with registered bus outputs.
module tpi_bus_arbiter
   import tpi_bus_arbiter_pkg::*;
#(
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic                 clock,
   input  logic                 _reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_write,
   input  logic [3*NUM_REQ-1:0] req_rs,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   ack,
   output logic [7:0]           rdata,
   output logic                 busy,
   output logic                 _cs,
   output logic [2:0]           rs,
   output logic                 _write,
   output logic [7:0]           data_o,
   output logic                 data_oe,
   input  logic [7:0]           data_i
);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 last_grant;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   grant_q;
   logic                 is_write;
   logic                 sel;

   rr_arbiter2 u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign sel = grant[1];

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         grant_q    <= '0;
         is_write   <= 1'b0;
         ack        <= '0;
         rdata      <= '0;
         busy       <= 1'b0;
         _cs        <= 1'b1;
         rs         <= '0;
         _write     <= 1'b1;
         data_o     <= '0;
         data_oe    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  grant_q    <= grant;
                  last_grant <= sel;
                  is_write   <= req_write[sel];
                  rs         <= sel ? req_rs[5:3] : req_rs[2:0];
                  data_o     <= sel ? req_wdata[15:8] : req_wdata[7:0];
                  data_oe    <= req_write[sel];
                  busy       <= 1'b1;
                  _cs        <= 1'b1;
                  _write     <= 1'b1;
                  cnt        <= load_count(SETUP_CYCLES);
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  _cs    <= 1'b0;
                  _write <= !is_write;
                  cnt    <= load_count(STROBE_CYCLES);
                  state  <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  _cs <= 1'b1;
                  if (!is_write) rdata <= data_i;
                  // ack is registered, so it is raised on entry to the final HOLD cycle.
                  if (HOLD_CYCLES == 1) ack <= grant_q;
                  cnt   <= load_count(HOLD_CYCLES);
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) ack <= grant_q;
               end else begin
                  _write  <= 1'b1;
                  data_oe <= 1'b0;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
